pong_score_keeper: RTL and testbench

Score-keeping controller for the two-player pong game. It turns ball-miss events from the playfield logic into per-player point scores, enforces a respawn hold-off after every point, detects the winner and tracks the serve side. Its `score_p1`/`score_p2` outputs feed the seven-segment score display directly, so it is the writer side of that display's score interface. It runs entirely in the 1 kHz display clock domain.

---
 rtl/pong_score_keeper_if.sv | 23 ++
 rtl/pong_score_keeper.sv | 152 +++++++++++++++
 tb/tb_pong_score_keeper.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/pong_score_keeper_if.sv
// Score interface between the playfield (miss/restart requests) and the score keeper,
// whose score outputs also feed the seven-segment display.
interface pong_score_keeper_if;
  logic       miss_p1;
  logic       miss_p2;
  logic       new_game;
  logic [3:0] score_p1;
  logic [3:0] score_p2;
  logic       point_flash;
  logic       game_over;
  logic [1:0] winner;
  logic       serve_p2;

  modport master (
    output miss_p1, miss_p2, new_game,
    input  score_p1, score_p2, point_flash, game_over, winner, serve_p2
  );

  modport slave (
    input  miss_p1, miss_p2, new_game,
    output score_p1, score_p2, point_flash, game_over, winner, serve_p2
  );
endinterface

// File: rtl/pong_score_keeper.sv
// Pong score keeper: synchronizes miss/restart levels into edge events, keeps both
// scores, enforces the post-point respawn hold-off, and tracks winner and serve side.
module pong_score_keeper #(
  parameter int unsigned WIN_SCORE      = 7,
  parameter int unsigned HOLDOFF_CYCLES = 500
) (
  input  logic               clk_1k,
  input  logic               reset,
  pong_score_keeper_if.slave sk
);

  typedef enum logic [1:0] {
    PLAY      = 2'd0,
    HOLDOFF   = 2'd1,
    GAME_OVER = 2'd2
  } state_e;

  localparam logic [3:0] WIN_L     = 4'(WIN_SCORE);
  localparam logic [9:0] HOLD_LOAD = 10'(HOLDOFF_CYCLES - 1);

  localparam int unsigned EV_M1 = 0;
  localparam int unsigned EV_M2 = 1;
  localparam int unsigned EV_NG = 2;

  logic [2:0] raw;
  logic [2:0] s1_q, s2_q, s3_q;
  logic [2:0] ev;

  state_e     state_q, state_d;
  logic [3:0] score1_q, score1_d;
  logic [3:0] score2_q, score2_d;
  logic [1:0] winner_q, winner_d;
  logic       serve_q, serve_d;
  logic [9:0] cnt_q, cnt_d;
  logic       flash_q, flash_d;
  logic       over_q, over_d;

  // Scores stop at WIN_SCORE; the FSM never asks for more, this just keeps digits legal.
  function automatic logic [3:0] bump(input logic [3:0] s);
    return (s >= WIN_L) ? WIN_L : s + 4'd1;
  endfunction

  assign raw = {sk.new_game, sk.miss_p2, sk.miss_p1};

  // Synchronizer: s1/s2 resolve metastability, s3 delays s2 for rising-edge detection.
  always_ff @(posedge clk_1k or posedge reset) begin
    if (reset) begin
      s1_q <= '0;
      s2_q <= '0;
      s3_q <= '0;
    end else begin
      s1_q <= raw;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign ev = s2_q & ~s3_q;

  always_ff @(posedge clk_1k or posedge reset) begin
    if (reset) begin
      state_q  <= PLAY;
      score1_q <= '0;
      score2_q <= '0;
      winner_q <= 2'b00;
      serve_q  <= 1'b0;
      cnt_q    <= '0;
      flash_q  <= 1'b0;
      over_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      score1_q <= score1_d;
      score2_q <= score2_d;
      winner_q <= winner_d;
      serve_q  <= serve_d;
      cnt_q    <= cnt_d;
      flash_q  <= flash_d;
      over_q   <= over_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    score1_d = score1_q;
    score2_d = score2_q;
    winner_d = winner_q;
    serve_d  = serve_q;
    cnt_d    = cnt_q;

    if (ev[EV_NG]) begin
      // Restart wins over any miss in the same cycle; the loser of a finished game serves.
      state_d  = PLAY;
      score1_d = '0;
      score2_d = '0;
      winner_d = 2'b00;
      cnt_d    = '0;
      if (state_q == GAME_OVER) begin
        serve_d = (winner_q == 2'b01);
      end
    end else begin
      unique case (state_q)
        PLAY: begin
          if (ev[EV_M2] && !ev[EV_M1]) begin
            score1_d = bump(score1_q);
            serve_d  = 1'b1;
            if (score1_d == WIN_L) begin
              state_d  = GAME_OVER;
              winner_d = 2'b01;
            end else begin
              state_d = HOLDOFF;
              cnt_d   = HOLD_LOAD;
            end
          end else if (ev[EV_M1] && !ev[EV_M2]) begin
            score2_d = bump(score2_q);
            serve_d  = 1'b0;
            if (score2_d == WIN_L) begin
              state_d  = GAME_OVER;
              winner_d = 2'b10;
            end else begin
              state_d = HOLDOFF;
              cnt_d   = HOLD_LOAD;
            end
          end
        end
        HOLDOFF: begin
          if (cnt_q == '0) begin
            state_d = PLAY;
          end else begin
            cnt_d = cnt_q - 10'd1;
          end
        end
        GAME_OVER: begin
          state_d = GAME_OVER;
        end
        default: begin
          state_d = PLAY;
        end
      endcase
    end

    flash_d = (state_d == HOLDOFF);
    over_d  = (state_d == GAME_OVER);
  end

  assign sk.score_p1    = score1_q;
  assign sk.score_p2    = score2_q;
  assign sk.point_flash = flash_q;
  assign sk.game_over   = over_q;
  assign sk.winner      = winner_q;
  assign sk.serve_p2    = serve_q;

endmodule

// File: tb/tb_pong_score_keeper.sv
// Scoreboard bench: instance A uses default parameters, instance B uses WIN_SCORE=3,
// HOLDOFF_CYCLES=4. Expected output snapshots (with their cycle) are queued ahead of time.
module tb_pong_score_keeper;

  logic clk_1k  = 1'b0;
  logic reset_a = 1'b0;
  logic reset_b = 1'b0;
  int   cyc     = 0;

  always #5 clk_1k = ~clk_1k;
  always @(posedge clk_1k) cyc <= cyc + 1;

  pong_score_keeper_if ifa ();
  pong_score_keeper_if ifb ();

  pong_score_keeper dut_a (
    .clk_1k (clk_1k),
    .reset  (reset_a),
    .sk     (ifa)
  );

  pong_score_keeper #(
    .WIN_SCORE      (3),
    .HOLDOFF_CYCLES (4)
  ) dut_b (
    .clk_1k (clk_1k),
    .reset  (reset_b),
    .sk     (ifb)
  );

  typedef struct packed {
    logic [3:0] s1;
    logic [3:0] s2;
    logic       fl;
    logic       go;
    logic [1:0] win;
    logic       sv;
  } snap_t;

  typedef struct {
    int    c;
    snap_t v;
    string name;
  } exp_t;

  exp_t  qa[$];
  exp_t  qb[$];
  int    checks   = 0;
  int    failures = 0;
  snap_t prev_a   = '1;
  snap_t prev_b   = '1;

  function automatic string fmt(input snap_t s);
    return $sformatf("s1=%0d s2=%0d flash=%0b over=%0b winner=%b serve=%0b",
                     s.s1, s.s2, s.fl, s.go, s.win, s.sv);
  endfunction

  function automatic snap_t snap_a();
    return '{ifa.score_p1, ifa.score_p2, ifa.point_flash, ifa.game_over, ifa.winner, ifa.serve_p2};
  endfunction

  function automatic snap_t snap_b();
    return '{ifb.score_p1, ifb.score_p2, ifb.point_flash, ifb.game_over, ifb.winner, ifb.serve_p2};
  endfunction

  task automatic expect_out(input bit which, input string nm, input int c,
                            input int s1, input int s2, input bit fl, input bit go,
                            input int win, input bit sv);
    exp_t e;
    e.c    = c;
    e.name = nm;
    e.v    = '{4'(s1), 4'(s2), fl, go, 2'(win), sv};
    if (which) qb.push_back(e);
    else       qa.push_back(e);
  endtask

  task automatic check_pop(input bit which, input snap_t act);
    exp_t e;
    checks++;
    if ((which && qb.size() == 0) || (!which && qa.size() == 0)) begin
      failures++;
      $display("FAIL %s unexpected_change: got %s at cyc %0d, required no change",
               which ? "B" : "A", fmt(act), cyc);
      return;
    end
    e = which ? qb.pop_front() : qa.pop_front();
    if (act !== e.v || (e.c >= 0 && e.c != cyc)) begin
      failures++;
      $display("FAIL %s %s: got %s at cyc %0d, required %s at cyc %0d",
               which ? "B" : "A", e.name, fmt(act), cyc, fmt(e.v), e.c);
    end
  endtask

  // Monitor: any change of a DUT's outputs consumes that DUT's next expected snapshot.
  always @(negedge clk_1k) begin
    if (snap_a() !== prev_a) check_pop(1'b0, snap_a());
    if (snap_b() !== prev_b) check_pop(1'b1, snap_b());
    prev_a <= snap_a();
    prev_b <= snap_b();
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk_1k);
    #1;
  endtask

  task automatic drive(input bit which, input bit m1, input bit m2, input bit ng);
    if (which) begin
      ifb.miss_p1 = m1; ifb.miss_p2 = m2; ifb.new_game = ng;
    end else begin
      ifa.miss_p1 = m1; ifa.miss_p2 = m2; ifa.new_game = ng;
    end
  endtask

  task automatic pulse(input bit which, input bit m1, input bit m2, input bit ng, input int len);
    drive(which, m1, m2, ng);
    step(len);
    drive(which, 1'b0, 1'b0, 1'b0);
  endtask

  // Instance A points after the first one: {miss_p2, score_p1, score_p2, serve_p2}
  int tbl_a [6][4] = '{
    '{1, 2, 1, 1}, '{1, 3, 1, 1}, '{0, 3, 2, 0},
    '{1, 4, 2, 1}, '{0, 4, 3, 0}, '{1, 5, 3, 1}
  };

  initial begin
    int c;
    int p;
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    expect_out(1'b0, "reset_state", -1, 0, 0, 0, 0, 0, 0);
    expect_out(1'b1, "reset_state", -1, 0, 0, 0, 0, 0, 0);
    #1;
    reset_a = 1'b1;
    reset_b = 1'b1;
    step(3);
    reset_a = 1'b0;
    reset_b = 1'b0;
    step(2);

    // ---------------- instance B: WIN_SCORE=3, HOLDOFF_CYCLES=4 ----------------
    pulse(1'b1, 1'b1, 1'b1, 1'b0, 3);   // void rally: no output change expected
    step(10);

    for (int i = 1; i <= 3; i++) begin
      c = cyc;
      if (i < 3) begin
        expect_out(1'b1, "B_p1_win_point", c + 3, i, 0, 1, 0, 0, 1);
        expect_out(1'b1, "B_p1_win_holdoff_end", c + 7, i, 0, 0, 0, 0, 1);
      end else begin
        expect_out(1'b1, "B_p1_wins", c + 3, 3, 0, 0, 1, 1, 1);
      end
      pulse(1'b1, 1'b0, 1'b1, 1'b0, 2);
      step(8);
    end
    pulse(1'b1, 1'b0, 1'b1, 1'b0, 2);   // frozen in GAME_OVER
    step(8);

    c = cyc;
    expect_out(1'b1, "B_new_game_after_p1_win", c + 3, 0, 0, 0, 0, 0, 1);
    pulse(1'b1, 1'b0, 1'b0, 1'b1, 2);
    step(8);

    for (int i = 1; i <= 3; i++) begin
      c = cyc;
      if (i < 3) begin
        expect_out(1'b1, "B_p2_win_point", c + 3, 0, i, 1, 0, 0, 0);
        expect_out(1'b1, "B_p2_win_holdoff_end", c + 7, 0, i, 0, 0, 0, 0);
      end else begin
        expect_out(1'b1, "B_p2_wins", c + 3, 0, 3, 0, 1, 2, 0);
      end
      pulse(1'b1, 1'b1, 1'b0, 1'b0, 2);
      step(8);
    end
    pulse(1'b1, 1'b1, 1'b0, 1'b0, 2);   // fourth miss leaves score_p2 at 3
    step(8);

    c = cyc;
    expect_out(1'b1, "B_new_game_after_p2_win", c + 3, 0, 0, 0, 0, 0, 0);
    pulse(1'b1, 1'b0, 1'b0, 1'b1, 2);
    step(8);

    c = cyc;
    expect_out(1'b1, "B_point_p1", c + 3, 1, 0, 1, 0, 0, 1);
    expect_out(1'b1, "B_point_p1_end", c + 7, 1, 0, 0, 0, 0, 1);
    pulse(1'b1, 1'b0, 1'b1, 1'b0, 2);
    step(8);

    c = cyc;
    expect_out(1'b1, "B_new_game_beats_miss", c + 3, 0, 0, 0, 0, 0, 1);
    pulse(1'b1, 1'b0, 1'b1, 1'b1, 2);
    step(10);

    c = cyc;
    expect_out(1'b1, "B_point_after_restart", c + 3, 0, 1, 1, 0, 0, 0);
    expect_out(1'b1, "B_point_after_restart_end", c + 7, 0, 1, 0, 0, 0, 0);
    pulse(1'b1, 1'b1, 1'b0, 1'b0, 2);
    step(10);

    // ---------------- instance A: defaults (7, 500) ----------------
    c = cyc;
    p = c + 3;
    expect_out(1'b0, "A_first_point", p, 1, 0, 1, 0, 0, 1);
    expect_out(1'b0, "A_first_holdoff_end", p + 500, 1, 0, 0, 0, 0, 1);
    pulse(1'b0, 1'b0, 1'b1, 1'b0, 3);
    step(2);                             // cyc == p + 2: miss inside hold-off
    pulse(1'b0, 1'b1, 1'b0, 1'b0, 3);
    step(p + 501 - cyc);                 // cyc == p + 501: counted again
    c = cyc;
    expect_out(1'b0, "A_miss_after_holdoff", c + 3, 1, 1, 1, 0, 0, 0);
    expect_out(1'b0, "A_miss_after_holdoff_end", c + 503, 1, 1, 0, 0, 0, 0);
    pulse(1'b0, 1'b1, 1'b0, 1'b0, 2);
    step(520);

    for (int k = 0; k < 6; k++) begin
      c = cyc;
      expect_out(1'b0, $sformatf("A_point_%0d", k), c + 3,
                 tbl_a[k][1], tbl_a[k][2], 1, 0, 0, tbl_a[k][3][0]);
      if (k < 5)
        expect_out(1'b0, $sformatf("A_point_%0d_end", k), c + 503,
                   tbl_a[k][1], tbl_a[k][2], 0, 0, 0, tbl_a[k][3][0]);
      pulse(1'b0, ~tbl_a[k][0][0], tbl_a[k][0][0], 1'b0, 2);
      step(k < 5 ? 520 : 12);
    end

    // 5-3 and inside HOLDOFF: reset must act on this very cycle
    expect_out(1'b0, "A_async_reset_in_holdoff", cyc, 0, 0, 0, 0, 0, 0);
    reset_a = 1'b1;
    step(3);
    reset_a = 1'b0;
    step(2);

    c = cyc;
    expect_out(1'b0, "A_point_after_reset", c + 3, 1, 0, 1, 0, 0, 1);
    expect_out(1'b0, "A_point_after_reset_end", c + 503, 1, 0, 0, 0, 0, 1);
    pulse(1'b0, 1'b0, 1'b1, 1'b0, 2);
    step(520);

    checks++;
    if (qa.size() != 0) begin
      failures++;
      $display("FAIL A pending_expectations: got %0d left, required 0 (next %s)", qa.size(), qa[0].name);
    end
    checks++;
    if (qb.size() != 0) begin
      failures++;
      $display("FAIL B pending_expectations: got %0d left, required 0 (next %s)", qb.size(), qb[0].name);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
